// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source with bounded draws.
// Draws use mask-and-reject sampling. When the retry cap is reached, the
// last candidate is folded back into range by a single subtraction.
module lfsr_rng #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
   parameter logic [WIDTH-1:0] SEED      = 16'hBEEF,
   parameter int               OUT_W     = 8,
   parameter int               MAX_TRIES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reseed,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             req,
   input  logic [OUT_W-1:0] limit,
   output logic             ack,
   output logic [OUT_W-1:0] value,
   output logic             busy,
   output logic [WIDTH-1:0] state,
   output logic             lockup
);

   localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

   // Reject illegal parameter sets while elaborating.
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_rng: SEED must be non-zero");
   end
   if (WIDTH < 2 || WIDTH < OUT_W) begin : g_bad_width
      $error("lfsr_rng: WIDTH must be >= 2 and >= OUT_W");
   end
   if (MAX_TRIES < 1) begin : g_bad_tries
      $error("lfsr_rng: MAX_TRIES must be >= 1");
   end

   typedef enum logic {S_IDLE, S_DRAW} fsm_t;

   fsm_t             r_fsm;
   logic [WIDTH-1:0] r_state;
   logic             r_reseed_d;
   logic             r_lockup;
   logic [OUT_W-1:0] r_lim;
   logic [OUT_W-1:0] r_mask;
   logic [TRY_W-1:0] r_tries;
   logic [OUT_W-1:0] r_value;
   logic             r_ack;
   logic             r_busy;

   logic             w_reseed_edge;
   logic [WIDTH-1:0] w_step;
   logic             w_do_step;
   logic [OUT_W-1:0] w_lim_m1;
   logic [OUT_W-1:0] w_mask;
   logic [OUT_W-1:0] w_cand;
   logic             w_accept;

   assign w_reseed_edge = reseed & ~r_reseed_d;
   assign w_step        = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
   // The entry step on an accepted req is part of the same rule as free-run.
   assign w_do_step     = (r_fsm == S_DRAW) || enable || req;
   assign w_lim_m1      = limit - OUT_W'(1);
   assign w_cand        = r_state[OUT_W-1:0] & r_mask;
   assign w_accept      = (r_lim == '0) || (w_cand < r_lim);

   // Smear-right of limit-1 gives the smallest all-ones mask covering the range.
   always_comb begin
      w_mask = w_lim_m1;
      for (int i = 1; i < OUT_W; i++) w_mask = w_mask | (w_lim_m1 >> i);
      if (limit == '0) w_mask = '1;
   end

   // LFSR state: load beats reseed edge, and a reseed edge beats the step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= SEED;
         r_reseed_d <= 1'b0;
         r_lockup   <= 1'b0;
      end else begin
         r_reseed_d <= reseed;
         r_lockup   <= load && (load_value == '0);
         if (load)               r_state <= (load_value == '0) ? SEED : load_value;
         else if (w_reseed_edge) r_state <= SEED;
         else if (w_do_step)     r_state <= w_step;
      end
   end

   // Draw FSM with registered ack, value and busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fsm   <= S_IDLE;
         r_lim   <= '0;
         r_mask  <= '0;
         r_tries <= '0;
         r_value <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_fsm)
            S_IDLE: begin
               if (req) begin
                  r_lim   <= limit;
                  r_mask  <= w_mask;
                  r_tries <= '0;
                  r_busy  <= 1'b1;
                  r_fsm   <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (w_accept) begin
                  r_value <= w_cand;
                  r_ack   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_fsm   <= S_IDLE;
               end else if (r_tries == LAST_TRY) begin
                  // cand < 2*lim, so one subtraction lands inside the range.
                  r_value <= w_cand - r_lim;
                  r_ack   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_fsm   <= S_IDLE;
               end else begin
                  r_tries <= r_tries + TRY_W'(1);
               end
            end
            default: r_fsm <= S_IDLE;
         endcase
      end
   end

   assign ack    = r_ack;
   assign value  = r_value;
   assign busy   = r_busy;
   assign state  = r_state;
   assign lockup = r_lockup;

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator for game and puzzle logic.
- Supports configurable width, tap mask and seed.
- Reseeds on the rising edge of a level input and supports direct state load with lock-up protection.
- Serves bounded random draws (value < limit) over a req/ack handshake using mask-and-reject sampling, with a capped retry count.

Parameters:
- WIDTH, 16, LFSR state width (>= OUT_W, >= 2).
- TAPS, 16'hB400, feedback tap mask; bit i set means state[i] enters the XOR feedback.
- SEED, 16'hBEEF, reset/reseed value; must be non-zero (elaboration-time check).
- OUT_W, 8, width of the draw result and limit.
- MAX_TRIES, 16, maximum candidate evaluations per draw (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- reseed  in  1  level input; a 0->1 transition (detected on clk) reloads SEED.
- enable  in  1  free-run step enable while idle.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value loaded when load=1.
- req  in  1  draw request, sampled only in IDLE.
- limit  in  OUT_W  exclusive upper bound of the draw; 0 means the full 2^OUT_W range.
- ack  out  1  one-cycle pulse: value is valid.
- value  out  OUT_W  draw result, held until the next ack.
- busy  out  1  high while in DRAW.
- state  out  WIDTH  current LFSR state.
- lockup  out  1  one-cycle pulse when an all-zero load was replaced by SEED.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=SEED, value=0, ack=0, busy=0, lockup=0.
  - FSM=IDLE, retry counter=0, reseed edge register=0.
- Step function: state <= {state[WIDTH-2:0], ^(state & TAPS)}. With the defaults, 0xBEEF steps to 0x7DDE.
- State update priority, per edge: load > reseed rising edge > step.
  - load with load_value != 0: state <= load_value.
  - load with load_value == 0: state <= SEED and lockup=1 for one cycle.
  - reseed edge: state <= SEED. A held-high reseed reloads only once.
  - Step occurs when FSM=DRAW, or when FSM=IDLE and enable=1. Otherwise state holds.
- Load or reseed during DRAW replaces that cycle's step. The draw continues from the new state and is not aborted.
- FSM states: IDLE, DRAW.
  - IDLE, req=1:
    - Latch limit into lim_r.
    - mask_r = smear-right of (lim_r-1); all ones if lim_r=0.
    - tries=0, busy=1, state steps, go to DRAW.
    - req is ignored outside IDLE.
  - DRAW, each cycle:
    - cand = state[OUT_W-1:0] & mask_r.
    - Accept if lim_r=0 or cand < lim_r: value<=cand, ack=1 (registered, one cycle), busy=0, go to IDLE.
    - Otherwise, if tries == MAX_TRIES-1: value <= cand - lim_r (always < lim_r, since cand < 2*lim_r), ack=1, go to IDLE.
    - Otherwise: tries++, stay in DRAW.
    - state steps every DRAW cycle, including the final one.
- Latency:
  - req sampled at edge k; first evaluation at edge k+1.
  - Best case: ack high in the cycle after edge k+1.
  - Worst case: ack after edge k+MAX_TRIES.
- ack and req may coincide: a new req sampled in the IDLE cycle where ack is high is accepted normally, giving back-to-back draws with one idle cycle.
- limit=1: mask=0, cand=0, always accepted, value=0.
- rst asserted mid-draw:
  - Immediate return to reset values.
  - No ack is produced for the aborted draw.

Test Plan:
- Reset then enable=1 for 2 cycles -> state 0xBEEF, then 0x7DDE, then 0xFBBD. ack=0, busy=0 throughout.
- From reset, enable=0, req=1 for one cycle with limit=10:
  - Entry step gives 0x7DDE.
  - Candidates 14, 13, 11 are rejected (states 0x7DDE, 0xFBBD, 0xF77B).
  - 0xEEF6 gives 6, accepted: ack after the 4th evaluation, value=6, busy high exactly 4 cycles.
- Same stimulus with MAX_TRIES=1 -> single evaluation, cand=14 rejected, value=4, ack at the first evaluation edge.
- load=1, load_value=0 -> next state=0xBEEF, lockup pulses once. load_value=0x1234 -> state=0x1234, no lockup.
- Step several cycles, then raise reseed and hold it high 5 cycles -> state=0xBEEF after the first edge, then normal stepping. No further reloads until reseed falls and rises again.
- Assert rst low during DRAW (limit=10) -> state=0xBEEF, busy=0, ack=0, value=0 immediately. No ack after release.
